// File: rtl/pair_product_accumulator.sv
// Accumulates product triples into a negacyclic (x^N = -1) polynomial held as
// coefficient pairs, then streams the pairs out under a valid/ready handshake.
module pair_product_accumulator #(
    parameter int N_PAIRS = 128,
    parameter int W       = 13
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           in_valid,
    input  logic [6:0]     in_pair,
    input  logic [W-1:0]   in_a0s0,
    input  logic [W-1:0]   in_mid,
    input  logic [W-1:0]   in_a1s1,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_data,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int IW = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_PAIRS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  k_q, k_d;
    logic           err_q, err_d;
    logic           done_q, done_d;
    logic           out_valid_q;
    logic [2*W-1:0] out_data_q;

    // lo holds coefficient 2k, hi holds coefficient 2k+1
    logic [W-1:0]   lo_q [N_PAIRS];
    logic [W-1:0]   hi_q [N_PAIRS];
    logic [W-1:0]   lo_d [N_PAIRS];
    logic [W-1:0]   hi_d [N_PAIRS];

    logic           clear, acc_en, pair_ok, wrap, accept;
    logic [IW-1:0]  j, jn;
    logic [W-1:0]   a1_eff;

    function automatic logic [W-1:0] term(input logic sel, input logic [W-1:0] v);
        return sel ? v : '0;
    endfunction

    assign pair_ok = (N_PAIRS >= 128) || ({25'd0, in_pair} < 32'(N_PAIRS));
    assign j       = in_pair[IW-1:0];
    assign wrap    = (j == LAST_IDX);
    assign jn      = wrap ? '0 : j + 1'b1;
    // The x^2 term of the top pair folds onto coefficient 0 with a sign flip
    assign a1_eff  = wrap ? -in_a1s1 : in_a1s1;
    assign accept  = (state_q == S_DRAIN) && out_valid_q && out_ready;

    always_comb begin
        for (int k = 0; k < N_PAIRS; k++) begin
            lo_d[k] = (clear ? '0 : lo_q[k])
                    + term(acc_en && (IW'(k) == j), in_a0s0)
                    + term(acc_en && (IW'(k) == jn), a1_eff);
            hi_d[k] = (clear ? '0 : hi_q[k])
                    + term(acc_en && (IW'(k) == j), in_mid);
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        err_d   = err_q;
        done_d  = 1'b0;
        clear   = 1'b0;
        acc_en  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    err_d   = 1'b0;
                    k_d     = '0;
                    state_d = S_ACCUM;
                end
                if (in_valid) err_d = 1'b1;
            end
            S_ACCUM: begin
                if (start) err_d = 1'b1;
                if (in_valid) begin
                    if (pair_ok) acc_en = 1'b1;
                    else         err_d  = 1'b1;
                    if (in_last) begin
                        state_d = S_DRAIN;
                        k_d     = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (start || in_valid) err_d = 1'b1;
                if (accept) begin
                    if (k_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        k_d     = '0;
                        done_d  = 1'b1;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            err_q       <= err_d;
            done_q      <= done_d;
            out_valid_q <= (state_d == S_DRAIN);
        end
    end

    // Output pair is taken from next-state values so the final triple is seen
    always_ff @(posedge clk) begin
        if (!rst) begin
            lo_q <= lo_d;
            hi_q <= hi_d;
            if (state_d == S_DRAIN) out_data_q <= {hi_d[k_d], lo_d[k_d]};
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pair_product_accumulator.sv
// Scoreboard bench: a coefficient-level negacyclic model predicts every drained pair.
module tb_pair_product_accumulator;

    localparam int N = 128;
    localparam int W = 13;
    localparam int M = 1 << W;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           in_valid = 1'b0;
    logic [6:0]     in_pair = '0;
    logic [W-1:0]   in_a0s0 = '0;
    logic [W-1:0]   in_mid = '0;
    logic [W-1:0]   in_a1s1 = '0;
    logic           in_last = 1'b0;
    logic           out_ready = 1'b0;
    logic           out_valid;
    logic [2*W-1:0] out_data;
    logic           busy, done, err;

    always #5 clk = ~clk;

    pair_product_accumulator #(.N_PAIRS(N), .W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_pair(in_pair), .in_a0s0(in_a0s0), .in_mid(in_mid), .in_a1s1(in_a1s1),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .done(done), .err(err)
    );

    int             n_vec = 0;
    int             n_bad = 0;
    int             mdl [2*N];
    logic [2*W-1:0] exp_q [$];
    int             pairs_left = 0;
    bit             done_pending = 1'b0;
    bit             held_v = 1'b0;
    logic [2*W-1:0] held_d;
    bit             mon_en = 1'b0;
    int             ready_mode = 0;
    int             pat = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Polynomial model: plain coefficient indices, x^(2N) = -1
    function automatic void model_add(int jj, int a, int b, int c);
        mdl[2*jj]   = (mdl[2*jj] + a) % M;
        mdl[2*jj+1] = (mdl[2*jj+1] + b) % M;
        if (2*jj + 2 >= 2*N) mdl[0] = (mdl[0] + M - c) % M;
        else                 mdl[2*jj+2] = (mdl[2*jj+2] + c) % M;
    endfunction

    function automatic void push_expected();
        logic [2*W-1:0] p;
        for (int k = 0; k < N; k++) begin
            p = {W'(mdl[2*k+1]), W'(mdl[2*k])};
            exp_q.push_back(p);
        end
        pairs_left = N;
    endfunction

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                out_ready = (pat % 4 == 0) || (pat % 4 == 3);
                pat++;
            end
        endcase
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("done", {31'd0, done}, {31'd0, done_pending});
            done_pending = 1'b0;
            if (held_v) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_data", {6'd0, out_data}, {6'd0, held_d});
                held_v = 1'b0;
            end
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_pair: got %0h, expected none", out_data);
                    end else begin
                        chk("pair", {6'd0, out_data}, {6'd0, exp_q.pop_front()});
                    end
                    pairs_left--;
                    if (pairs_left == 0) done_pending = 1'b1;
                end else begin
                    held_v = 1'b1;
                    held_d = out_data;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_acc();
        for (int i = 0; i < 2*N; i++) mdl[i] = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic triple(input int jj, input int a, input int b, input int c,
                          input bit last, input bit apply);
        in_valid = 1'b1;
        in_pair  = 7'(jj);
        in_a0s0  = W'(a);
        in_mid   = W'(b);
        in_a1s1  = W'(c);
        in_last  = last;
        if (apply) model_add(jj, a, b, c);
        if (last && apply) push_expected();
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic rand_triples(input int n);
        for (int i = 0; i < n; i++)
            triple(int'($urandom_range(0, N-1)), int'($urandom_range(0, M-1)),
                   int'($urandom_range(0, M-1)), int'($urandom_range(0, M-1)),
                   (i == n-1), 1'b1);
    endtask

    task automatic wait_idle();
        int i = 0;
        while ((busy !== 1'b0 || out_valid !== 1'b0) && i < 5000) begin
            tick();
            i++;
        end
        if (i >= 5000) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: busy=%0b out_valid=%0b after %0d cycles", busy, out_valid, i);
        end
        tick();
        chk("xfer_count", 32'(pairs_left), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // single triple at pair 0
        ready_mode = 0;
        new_acc();
        chk("busy_accum", {31'd0, busy}, 32'd1);
        triple(0, 5, 7, 9, 1'b1, 1'b1);
        wait_idle();

        // negacyclic wrap at the top pair
        new_acc();
        triple(127, 1, 2, 3, 1'b0, 1'b1);
        triple(127, 0, 0, 1, 1'b1, 1'b1);
        wait_idle();

        // modular overflow
        new_acc();
        triple(3, 8191, 8191, 8191, 1'b0, 1'b1);
        triple(3, 8191, 8191, 8191, 1'b1, 1'b1);
        wait_idle();

        // stall pattern 1,0,0,1
        ready_mode = 2;
        pat = 0;
        new_acc();
        rand_triples(30);
        wait_idle();

        // random accumulations with random backpressure
        ready_mode = 1;
        for (int r = 0; r < 4; r++) begin
            new_acc();
            rand_triples(int'($urandom_range(20, 200)));
            wait_idle();
        end

        // reset in the middle of a drain
        ready_mode = 0;
        new_acc();
        rand_triples(10);
        for (int i = 0; i < 1000 && pairs_left > N - 40; i++) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        exp_q.delete();
        pairs_left   = 0;
        held_v       = 1'b0;
        done_pending = 1'b0;
        rst = 1'b0;
        new_acc();
        triple(5, 1, 2, 3, 1'b1, 1'b1);
        wait_idle();

        // protocol errors
        triple(0, 1, 1, 1, 1'b0, 1'b0);
        chk("err_idle_valid", {31'd0, err}, 32'd1);
        tick();
        chk("err_sticky", {31'd0, err}, 32'd1);
        new_acc();
        chk("err_cleared", {31'd0, err}, 32'd0);
        triple(2, 10, 20, 30, 1'b0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_start_busy", {31'd0, err}, 32'd1);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        triple(2, 1, 1, 1, 1'b1, 1'b1);
        triple(0, 100, 100, 100, 1'b0, 1'b0);
        wait_idle();
        chk("err_after_drain", {31'd0, err}, 32'd1);
        new_acc();
        chk("err_cleared2", {31'd0, err}, 32'd0);
        triple(0, 0, 0, 0, 1'b1, 1'b1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pair_product_accumulator.md
PAIR_PRODUCT_ACCUMULATOR -- requirements
Module: pair_product_accumulator

Interface
REQ-001 Parameter N_PAIRS, default 128: number of 2-coefficient pairs in the result polynomial (256 coefficients, negacyclic, x^256 = -1).
REQ-002 Parameter W, default 13: coefficient width; all arithmetic is mod 2^W.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse; begins a new accumulation.
REQ-006 in_valid  input  1  a product triple is presented this cycle.
REQ-007 in_pair  input  7  pair index j (0..N_PAIRS-1); the triple lands at coefficient base 2j.
REQ-008 in_a0s0  input  W  constant-term product, added to coefficient 2j.
REQ-009 in_mid  input  W  cross-term product (a0s1+a1s0), added to coefficient 2j+1.
REQ-010 in_a1s1  input  W  x^2-term product, added to coefficient 2j+2.
REQ-011 in_last  input  1  qualifies with in_valid; marks the final triple of the accumulation.
REQ-012 out_valid  output  1  out_data holds a valid result pair.
REQ-013 out_ready  input  1  downstream accepts out_data when high with out_valid.
REQ-014 out_data  output  2W  result pair {coef 2k+1, coef 2k}, k = out index.
REQ-015 busy  output  1  high in ACCUM or DRAIN.
REQ-016 done  output  1  one-cycle pulse after the final pair is accepted.
REQ-017 err  output  1  sticky protocol-error flag.

Function
REQ-018 The block SHALL hold N_PAIRS x 2W accumulator registers and implement states IDLE, ACCUM, DRAIN.
REQ-019 IDLE + start: all accumulators cleared to 0 and state = ACCUM on the next edge; err cleared.
REQ-020 ACCUM accepts one triple per cycle, no backpressure; accumulator update visible the cycle after acceptance.
REQ-021 Update: acc[2j] += in_a0s0; acc[2j+1] += in_mid; acc[2j+2] += in_a1s1; all mod 2^W, carries discarded.
REQ-022 Wrap: for j = N_PAIRS-1, coefficient 2j+2 is index 0 and SHALL receive acc[0] -= in_a1s1 (negacyclic).
REQ-023 Triple to pair j touches only pair j and pair j+1 (mod N_PAIRS); one triple per cycle, so no write conflicts arise.
REQ-024 in_valid & in_last in ACCUM: the triple is accumulated and state = DRAIN on the next edge.
REQ-025 DRAIN streams pairs k = 0..N_PAIRS-1 in order; out_valid high throughout; k advances only on out_valid & out_ready.
REQ-026 out_data and out_valid SHALL be registered and stable while out_valid & !out_ready.
REQ-027 Acceptance of k = N_PAIRS-1: next edge state = IDLE, out_valid = 0, done = 1 for exactly one cycle.
REQ-028 in_valid in IDLE or DRAIN is ignored (no accumulator change) and sets err.
REQ-029 start while busy is ignored and sets err; state and accumulators are unchanged.
REQ-030 in_pair >= N_PAIRS when N_PAIRS < 128: triple discarded, err set.
REQ-031 Accumulators SHALL retain their values in IDLE after DRAIN until the next start.

Reset
REQ-032 rst high on any edge, including mid-ACCUM or mid-DRAIN: state = IDLE, out_valid = 0, done = 0, err = 0, busy = 0, out index = 0.
REQ-033 Accumulator contents are not required to be cleared by rst; start is the only clear.
REQ-034 Inputs are ignored on the edge where rst is high.

Verification
REQ-035 start; triple j=0 (5, 7, 9) with in_last; out_ready = 1 -> pair0 = {7,5}, pair1 = {0,9}, all other pairs 0, done one cycle after pair 127.
REQ-036 start; j=127 triples (1,2,3) then (0,0,1) with last -> acc[254]=1, acc[255]=2, acc[0] = 8188 (-4 mod 8192).
REQ-037 start; j=3 triple (8191,8191,8191) twice -> acc[6]=acc[7]=acc[8]=8190 (mod wrap).
REQ-038 DRAIN with out_ready toggling 1,0,0,1 -> out_data held stable while stalled, no pair skipped or repeated, 128 transfers total.
REQ-039 Assert rst during DRAIN at k=40 -> next cycle out_valid=0, busy=0; new start restarts cleanly at k=0 with accumulators zeroed.
REQ-040 in_valid in IDLE and start in ACCUM -> err = 1 and sticky, accumulators unchanged; cleared by next accepted start.
